// File: rtl/sm_test_pkg.sv
// Shared definitions for the sm_test stream stimulus blocks.
package sm_test_pkg;

   // Burst controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Right-shifting Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 0,2,3,5)
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // One LFSR step: XOR of tapped bits shifts in at the top
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

   // Throttle decision bit taken from the LFSR state
   function automatic logic lfsr_gap(input logic [15:0] s);
      return s[0];
   endfunction

endpackage

// File: rtl/sm_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and advance enable.
module sm_lfsr16
   import sm_test_pkg::*;
#(
   parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        adv,
   output logic [15:0] state
);

   // Load wins over advance so a new burst always restarts the sequence
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     state <= RESET_SEED;
      else if (load) state <= seed;
      else if (adv)  state <= lfsr_next(state);
   end

endmodule

// File: rtl/stream_gen.sv
// Valid/ready burst source: incrementing data, optional LFSR-driven valid gaps.
module stream_gen
   import sm_test_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter int          CNT_W     = 16,
   parameter int unsigned DATA_BASE = 0,
   parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_throttle,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   localparam logic [WIDTH-1:0] BASE = WIDTH'(DATA_BASE);

   state_t           state, state_nx;
   logic [CNT_W-1:0] remain;      // beats not yet transferred, including the one on offer
   logic             throttle_r;
   logic             valid_nx;
   logic [15:0]      lfsr;
   logic             xfer, last, load;

   assign xfer = o_valid & i_ready;
   assign last = (remain == CNT_W'(1));
   assign load = (state == ST_IDLE) && i_start && (i_count != '0);

   sm_lfsr16 #(.RESET_SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .seed  (LFSR_SEED),
      .adv   (state == ST_RUN),
      .state (lfsr)
   );

   // Next state and next-cycle valid; valid only re-decides when the slot is free
   always_comb begin
      state_nx = state;
      valid_nx = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) state_nx = (i_count != '0) ? ST_RUN : ST_DONE;
         end
         ST_RUN: begin
            if (xfer && last) begin
               state_nx = ST_DONE;
               valid_nx = 1'b0;
            end else if (!o_valid || xfer) begin
               valid_nx = throttle_r ? lfsr_gap(lfsr) : 1'b1;
            end else begin
               valid_nx = 1'b1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         remain     <= '0;
         throttle_r <= 1'b0;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_data     <= '0;
      end else begin
         state  <= state_nx;
         o_busy <= (state_nx == ST_RUN);
         o_done <= (state_nx == ST_DONE);
         case (state)
            ST_IDLE: begin
               o_valid <= 1'b0;
               if (load) begin
                  remain     <= i_count;
                  throttle_r <= i_throttle;
                  o_data     <= BASE;
                  // First offer uses the seed bit, same as the LFSR's first RUN cycle
                  o_valid    <= i_throttle ? lfsr_gap(LFSR_SEED) : 1'b1;
               end
            end
            ST_RUN: begin
               o_valid <= valid_nx;
               if (xfer) begin
                  remain <= remain - CNT_W'(1);
                  // Hold the final value after the last beat
                  if (!last) o_data <= o_data + WIDTH'(1);
               end
            end
            default: o_valid <= 1'b0;
         endcase
      end
   end

endmodule
